// File: rtl/fifo_in_16_out_32_if.sv
// Half-word producer / packed-word consumer bundle for the 16->32 receive packer.
// master drives strobes and data in; slave is the FIFO side.
interface fifo_in_16_out_32_if #(
  parameter int CNTR_WIDTH = 9
);
  logic                  clr_i;
  logic [15:0]           dat_i;
  logic                  enq_en_i;
  logic                  enq_rdy_o;
  logic [31:0]           dat_o;
  logic                  deq_en_i;
  logic                  deq_rdy_o;
  logic                  pending_o;
  logic [CNTR_WIDTH:0]   count_o;

  modport master (
    output clr_i, dat_i, enq_en_i, deq_en_i,
    input  enq_rdy_o, dat_o, deq_rdy_o, pending_o, count_o
  );

  modport slave (
    input  clr_i, dat_i, enq_en_i, deq_en_i,
    output enq_rdy_o, dat_o, deq_rdy_o, pending_o, count_o
  );
endinterface

// File: rtl/fifo_in_16_out_32.sv
// Receive-side 16->32 packer with a show-ahead word FIFO for the DSP path.
// First half-word of a pair lands in [15:0], second in [31:16].
module fifo_in_16_out_32 #(
  parameter int FIFOSIZE   = 512,
  parameter int CNTR_WIDTH = 9
) (
  input  logic dsp_clk,
  input  logic dsp_rst_n,
  fifo_in_16_out_32_if.slave bus
);
  // state | meaning
  // EMPTY | no half-word held; next accepted half-word becomes the low half
  // HALF  | lo_q holds the low half; next accepted half-word completes a word

  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} pack_state_t;

  // FIFOSIZE must be 2**CNTR_WIDTH: pointers wrap naturally and only count tells full from empty.
  localparam logic [CNTR_WIDTH:0]   FULL_CNT = (CNTR_WIDTH+1)'(FIFOSIZE);
  localparam logic [CNTR_WIDTH:0]   CNT_ONE  = {{CNTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [CNTR_WIDTH-1:0] PTR_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

  pack_state_t           state_q;
  logic [15:0]           lo_q;
  logic [31:0]           mem [FIFOSIZE];
  logic [CNTR_WIDTH-1:0] wp_q;
  logic [CNTR_WIDTH-1:0] rp_q;
  logic [CNTR_WIDTH:0]   count_q;

  logic flush;
  logic enq_rdy;
  logic deq_rdy;
  logic enq_ok;
  logic deq_ok;
  logic wr_en;

  assign flush   = !dsp_rst_n || bus.clr_i;
  // The closing half needs room as of the registered count; a same-cycle dequeue does not help it.
  assign enq_rdy = (state_q == EMPTY) || (count_q != FULL_CNT);
  assign deq_rdy = (count_q != '0);
  assign enq_ok  = bus.enq_en_i && enq_rdy;
  assign deq_ok  = bus.deq_en_i && deq_rdy;
  assign wr_en   = enq_ok && (state_q == HALF);

  always_ff @(posedge dsp_clk) begin
    if (flush) begin
      state_q <= EMPTY;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (enq_ok) begin
            lo_q    <= bus.dat_i;
            state_q <= HALF;
          end
        end
        HALF: begin
          if (enq_ok) state_q <= EMPTY;
        end
        default: state_q <= EMPTY;
      endcase

      if (wr_en)  wp_q <= wp_q + PTR_ONE;
      if (deq_ok) rp_q <= rp_q + PTR_ONE;

      if (wr_en && !deq_ok)      count_q <= count_q + CNT_ONE;
      else if (!wr_en && deq_ok) count_q <= count_q - CNT_ONE;
    end
  end

  always_ff @(posedge dsp_clk) begin
    if (wr_en && !flush) mem[wp_q] <= {bus.dat_i, lo_q};
  end

  assign bus.dat_o     = mem[rp_q];
  assign bus.enq_rdy_o = enq_rdy;
  assign bus.deq_rdy_o = deq_rdy;
  assign bus.pending_o = (state_q == HALF);
  assign bus.count_o   = count_q;
endmodule

// File: tb/tb_fifo_in_16_out_32.sv
// Bench for fifo_in_16_out_32: vector table, directed corner sequences and a
// random stream checked against a queue-based reference model.
module tb_fifo_in_16_out_32;
  localparam int FIFOSIZE   = 512;
  localparam int CNTR_WIDTH = 9;

  logic dsp_clk = 1'b0;
  logic dsp_rst_n = 1'b0;

  fifo_in_16_out_32_if #(.CNTR_WIDTH(CNTR_WIDTH)) bus ();

  fifo_in_16_out_32 #(.FIFOSIZE(FIFOSIZE), .CNTR_WIDTH(CNTR_WIDTH)) dut (
    .dsp_clk  (dsp_clk),
    .dsp_rst_n(dsp_rst_n),
    .bus      (bus)
  );

  always #5 dsp_clk = ~dsp_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: packed words in order, plus the held low half
  logic [31:0] mq[$];
  bit          m_pend = 1'b0;
  logic [15:0] m_held = '0;

  typedef struct {
    bit          enq;
    logic [15:0] d;
    bit          deq;
    bit          clr;
    bit          e_enq_rdy;
    bit          e_deq_rdy;
    bit          e_pend;
    int          e_cnt;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_model();
    chk("m_enq_rdy", 32'(bus.enq_rdy_o), 32'(!m_pend || mq.size() != FIFOSIZE));
    chk("m_deq_rdy", 32'(bus.deq_rdy_o), 32'(mq.size() != 0));
    chk("m_pending", 32'(bus.pending_o), 32'(m_pend));
    chk("m_count",   32'(bus.count_o),   32'(mq.size()));
    if (mq.size() != 0) chk("m_dat", bus.dat_o, mq[0]);
  endtask

  function automatic bit model_enq_acc(input bit enq);
    return enq && (!m_pend || mq.size() != FIFOSIZE);
  endfunction

  function automatic bit model_deq_acc(input bit deq);
    return deq && (mq.size() != 0);
  endfunction

  task automatic drive(input bit enq, input logic [15:0] d, input bit deq, input bit clr);
    bit enq_acc, deq_acc, rst_s;
    enq_acc = model_enq_acc(enq);
    deq_acc = model_deq_acc(deq);
    rst_s   = dsp_rst_n;
    bus.enq_en_i = enq;
    bus.dat_i    = d;
    bus.deq_en_i = deq;
    bus.clr_i    = clr;
    @(posedge dsp_clk);
    #1;
    bus.enq_en_i = 1'b0;
    bus.deq_en_i = 1'b0;
    bus.clr_i    = 1'b0;
    if (clr || !rst_s) begin
      mq.delete();
      m_pend = 1'b0;
    end else begin
      if (deq_acc) void'(mq.pop_front());
      if (enq_acc) begin
        if (m_pend) begin
          mq.push_back({d, m_held});
          m_pend = 1'b0;
        end else begin
          m_held = d;
          m_pend = 1'b1;
        end
      end
    end
    check_model();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, cyc, max_cnt, p;
    bit enq, deq;

    bus.clr_i = 1'b0; bus.dat_i = '0; bus.enq_en_i = 1'b0; bus.deq_en_i = 1'b0;

    tbl[0]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 32'h0};
    tbl[1]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 32'h22221111};
    tbl[2]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 32'h22221111};
    tbl[3]  = '{1'b1, 16'h4444, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 32'h44443333};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0};
    tbl[6]  = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 32'h0};
    tbl[7]  = '{1'b1, 16'hBBBB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0};
    tbl[8]  = '{1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 32'h0};
    tbl[9]  = '{1'b1, 16'hDDDD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 32'hDDDDCCCC};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0};

    // reset for two cycles
    dsp_rst_n = 1'b0;
    drive(0, '0, 0, 0);
    drive(0, '0, 0, 0);
    dsp_rst_n = 1'b1;
    chk("rst_enq_rdy", 32'(bus.enq_rdy_o), 32'd1);
    chk("rst_deq_rdy", 32'(bus.deq_rdy_o), 32'd0);
    chk("rst_pending", 32'(bus.pending_o), 32'd0);
    chk("rst_count",   32'(bus.count_o),   32'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].enq, tbl[i].d, tbl[i].deq, tbl[i].clr);
      chk("t_enq_rdy", 32'(bus.enq_rdy_o), 32'(tbl[i].e_enq_rdy));
      chk("t_deq_rdy", 32'(bus.deq_rdy_o), 32'(tbl[i].e_deq_rdy));
      chk("t_pending", 32'(bus.pending_o), 32'(tbl[i].e_pend));
      chk("t_count",   32'(bus.count_o),   32'(tbl[i].e_cnt));
      if (tbl[i].e_deq_rdy) chk("t_dat", bus.dat_o, tbl[i].e_dat);
    end

    // fill to full, hold one extra half, then drain
    drive(0, '0, 0, 1);
    for (int i = 0; i < 1024; i++) drive(1, 16'(i), 0, 0);
    chk("full_count",   32'(bus.count_o),   32'd512);
    chk("full_enq_rdy", 32'(bus.enq_rdy_o), 32'd1);
    drive(1, 16'h0400, 0, 0);
    chk("full_pending", 32'(bus.pending_o), 32'd1);
    chk("full_blocked", 32'(bus.enq_rdy_o), 32'd0);
    drive(1, 16'h0777, 0, 0);
    chk("full_ignored", 32'(bus.count_o), 32'd512);
    for (int k = 0; k < 512; k++) begin
      chk("drain_word", bus.dat_o, {16'(2*k+1), 16'(2*k)});
      if (k == 511) chk("last_word", bus.dat_o, 32'h03FF03FE);
      drive(0, '0, 1, 0);
      if (k == 0) chk("enq_rdy_after_deq", 32'(bus.enq_rdy_o), 32'd1);
    end
    chk("drained_count", 32'(bus.count_o), 32'd0);
    drive(1, 16'h0401, 0, 0);
    chk("held_pair", bus.dat_o, 32'h04010400);

    // simultaneous enq/deq at count=3, pending=1
    drive(0, '0, 0, 1);
    for (int i = 0; i < 7; i++) drive(1, 16'(16'h0100 + i), 0, 0);
    chk("sim_pre_count", 32'(bus.count_o), 32'd3);
    drive(1, 16'h0107, 1, 0);
    chk("sim_count", 32'(bus.count_o), 32'd3);
    chk("sim_head",  bus.dat_o, 32'h01030102);
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 0);
    chk("sim_tail",  bus.dat_o, 32'h01070106);

    // clr mid-pair with concurrent strobes
    drive(0, '0, 0, 1);
    for (int i = 0; i < 11; i++) drive(1, 16'(16'h0200 + i), 0, 0);
    chk("clr_pre_count", 32'(bus.count_o), 32'd5);
    drive(1, 16'h0999, 1, 1);
    chk("clr_count",   32'(bus.count_o),   32'd0);
    chk("clr_pending", 32'(bus.pending_o), 32'd0);
    chk("clr_deq_rdy", 32'(bus.deq_rdy_o), 32'd0);
    drive(1, 16'hBEEF, 0, 0);
    drive(1, 16'hCAFE, 0, 0);
    chk("clr_repack", bus.dat_o, 32'hCAFEBEEF);

    // random stream with wrap-around
    drive(0, '0, 0, 1);
    sent = 0; got = 0; cyc = 0; max_cnt = 0;
    while (got < 2000 && cyc < 40000) begin
      p   = ((cyc / 300) % 2) ? 85 : 25;
      enq = (sent < 4000) && ($urandom_range(0, 99) < 80);
      deq = ($urandom_range(0, 99) < p);
      if (model_enq_acc(enq)) sent++;
      if (model_deq_acc(deq)) got++;
      drive(enq, 16'($urandom), deq, 0);
      if (int'(bus.count_o) > max_cnt) max_cnt = int'(bus.count_o);
      cyc++;
    end
    chk("stream_done", 32'(got), 32'd2000);
    chk("stream_max_count", 32'(max_cnt <= FIFOSIZE), 32'd1);

    // reset while full and mid-pair
    drive(0, '0, 0, 1);
    for (int i = 0; i < 1025; i++) drive(1, 16'(i), 0, 0);
    chk("rf_blocked", 32'(bus.enq_rdy_o), 32'd0);
    dsp_rst_n = 1'b0;
    drive(1, 16'h1234, 1, 0);
    dsp_rst_n = 1'b1;
    chk("rf_enq_rdy", 32'(bus.enq_rdy_o), 32'd1);
    chk("rf_deq_rdy", 32'(bus.deq_rdy_o), 32'd0);
    chk("rf_pending", 32'(bus.pending_o), 32'd0);
    chk("rf_count",   32'(bus.count_o),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
